// File: rtl/bp_mem_cmd_xbar_pkg.sv
// Shared constants for the memory command crossbar: device IDs, DRAM base and target indices.
package bp_mem_cmd_xbar_pkg;

  localparam logic [3:0]  host_dev_gp  = 4'd1;
  localparam logic [3:0]  clint_dev_gp = 4'd2;
  localparam logic [39:0] dram_base_gp = 40'h00_8000_0000;

  typedef enum logic [1:0] {
    tgt_mem_e   = 2'd0,
    tgt_host_e  = 2'd1,
    tgt_clint_e = 2'd2
  } tgt_e;

endpackage

// File: rtl/bp_mem_cmd_xbar_if.sv
// Requester- and target-side bundle of the memory command crossbar.
interface bp_mem_cmd_xbar_if #(
  parameter int num_req_p   = 2,
  parameter int num_tgt_p   = 3,
  parameter int msg_width_p = 512
);

  logic [num_req_p*msg_width_p-1:0] req_cmd_i;
  logic [num_req_p-1:0]             req_cmd_v_i;
  logic [num_req_p-1:0]             req_cmd_ready_o;
  logic [num_req_p*msg_width_p-1:0] req_resp_o;
  logic [num_req_p-1:0]             req_resp_v_o;
  logic [num_req_p-1:0]             req_resp_yumi_i;
  logic [num_tgt_p*msg_width_p-1:0] tgt_cmd_o;
  logic [num_tgt_p-1:0]             tgt_cmd_v_o;
  logic [num_tgt_p-1:0]             tgt_cmd_ready_i;
  logic [num_tgt_p*msg_width_p-1:0] tgt_resp_i;
  logic [num_tgt_p-1:0]             tgt_resp_v_i;
  logic [num_tgt_p-1:0]             tgt_resp_yumi_o;
  logic [num_req_p-1:0]             credits_full_o;
  logic [num_req_p-1:0]             credits_empty_o;
  logic                             err_o;

  modport slave (
    input  req_cmd_i, req_cmd_v_i, req_resp_yumi_i, tgt_cmd_ready_i, tgt_resp_i, tgt_resp_v_i,
    output req_cmd_ready_o, req_resp_o, req_resp_v_o, tgt_cmd_o, tgt_cmd_v_o, tgt_resp_yumi_o,
           credits_full_o, credits_empty_o, err_o
  );

  modport master (
    output req_cmd_i, req_cmd_v_i, req_resp_yumi_i, tgt_cmd_ready_i, tgt_resp_i, tgt_resp_v_i,
    input  req_cmd_ready_o, req_resp_o, req_resp_v_o, tgt_cmd_o, tgt_cmd_v_o, tgt_resp_yumi_o,
           credits_full_o, credits_empty_o, err_o
  );

endinterface

// File: rtl/bp_mem_cmd_xbar_rr_arb.sv
// Round-robin or fixed-priority arbiter; the grant is held until a handshake so a stalled
// winner cannot be displaced by a newly arriving request.
module bp_mem_cmd_xbar_rr_arb #(
  parameter int n_p   = 2,
  parameter bit rr_p  = 1'b1,
  localparam int idx_w = (n_p > 1) ? $clog2(n_p) : 1
) (
  input  logic             clk_i,
  input  logic             reset_n_i,
  input  logic [n_p-1:0]   req,
  input  logic             advance,
  output logic [n_p-1:0]   grant,
  output logic [idx_w-1:0] idx,
  output logic             v
);

  logic [idx_w-1:0] ptr_reg, lock_idx_reg, base;
  logic             lock_reg;
  int               s;

  always_comb begin
    base  = rr_p ? ptr_reg : '0;
    idx   = '0;
    v     = 1'b0;
    s     = 0;
    // Scan downwards so the last hit is the first requester at or after the pointer.
    for (int i = n_p - 1; i >= 0; i--) begin
      s = int'(base) + i;
      if (s >= n_p) s = s - n_p;
      if (req[s]) begin
        idx = idx_w'(s);
        v   = 1'b1;
      end
    end
    if (lock_reg && req[lock_idx_reg]) idx = lock_idx_reg;
    grant = '0;
    if (v) grant[idx] = 1'b1;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      ptr_reg      <= '0;
      lock_reg     <= 1'b0;
      lock_idx_reg <= '0;
    end else begin
      lock_reg     <= v & ~advance;
      lock_idx_reg <= idx;
      if (rr_p && v && advance)
        ptr_reg <= (idx == idx_w'(n_p - 1)) ? '0 : idx + idx_w'(1);
    end
  end

endmodule

// File: rtl/bp_mem_cmd_xbar.sv
// Crossbar between cache engines and memory-side targets: buffered, address-decoded command
// path with per-target arbitration, lce_id-steered response path and per-requester credits.
module bp_mem_cmd_xbar
  import bp_mem_cmd_xbar_pkg::*;
#(
  parameter int num_req_p         = 2,
  parameter int num_tgt_p         = 3,
  parameter int msg_width_p       = 512,
  parameter int addr_lsb_p        = 0,
  parameter int addr_width_p      = 40,
  parameter int id_lsb_p          = 40,
  parameter int id_width_p        = 4,
  parameter int fifo_els_p        = 2,
  parameter int max_outstanding_p = 4,
  parameter logic [addr_width_p-1:0]    dram_base_p   = addr_width_p'(dram_base_gp),
  parameter int dev_lsb_p         = 20,
  parameter logic [4*(num_tgt_p-1)-1:0] tgt_dev_map_p = {clint_dev_gp, host_dev_gp},
  parameter bit rr_mode_p         = 1'b1
) (
  input logic              clk_i,
  input logic              reset_n_i,
  bp_mem_cmd_xbar_if.slave bus
);

  localparam int ptr_w  = $clog2(fifo_els_p);
  localparam int fcnt_w = $clog2(fifo_els_p + 1);
  localparam int cred_w = $clog2(max_outstanding_p + 1);
  localparam int ridx_w = (num_req_p > 1) ? $clog2(num_req_p) : 1;
  localparam int tidx_w = (num_tgt_p > 1) ? $clog2(num_tgt_p) : 1;

  logic [msg_width_p-1:0] head       [num_req_p];
  logic [num_tgt_p-1:0]   head_tgt   [num_req_p];
  logic [num_req_p-1:0]   cmd_grant  [num_tgt_p];
  logic [ridx_w-1:0]      cmd_idx    [num_tgt_p];
  logic [num_tgt_p-1:0]   resp_grant [num_req_p];
  logic [tidx_w-1:0]      resp_idx   [num_req_p];
  logic [id_width_p-1:0]  resp_id    [num_tgt_p];
  logic [num_req_p-1:0]   head_v, deq, cred_full, cred_empty, resp_acc, underflow;
  logic [num_tgt_p-1:0]   cmd_hs, resp_v, resp_bad;
  logic                   err_reg;

  genvar gi;
  generate
    for (gi = 0; gi < num_req_p; gi++) begin : g_req
      logic [msg_width_p-1:0]  mem_reg [fifo_els_p];
      logic [ptr_w-1:0]        wr_ptr_reg, rd_ptr_reg;
      logic [fcnt_w-1:0]       count_reg;
      logic [cred_w-1:0]       cnt_reg;
      logic [addr_width_p-1:0] addr;
      logic [num_tgt_p-1:0]    dec, rreq;
      logic                    enq;

      assign bus.req_cmd_ready_o[gi] = reset_n_i && (count_reg != fcnt_w'(fifo_els_p));
      assign enq        = bus.req_cmd_v_i[gi] & bus.req_cmd_ready_o[gi];
      assign head[gi]   = mem_reg[rd_ptr_reg];
      assign head_v[gi] = (count_reg != '0);

      always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
          wr_ptr_reg <= '0;
          rd_ptr_reg <= '0;
          count_reg  <= '0;
        end else begin
          if (enq)
            wr_ptr_reg <= (wr_ptr_reg == ptr_w'(fifo_els_p - 1)) ? '0 : wr_ptr_reg + ptr_w'(1);
          if (deq[gi])
            rd_ptr_reg <= (rd_ptr_reg == ptr_w'(fifo_els_p - 1)) ? '0 : rd_ptr_reg + ptr_w'(1);
          count_reg <= count_reg + fcnt_w'(enq) - fcnt_w'(deq[gi]);
        end
      end

      always_ff @(posedge clk_i) begin
        if (enq) mem_reg[wr_ptr_reg] <= bus.req_cmd_i[gi*msg_width_p +: msg_width_p];
      end

      // DRAM space and unmapped device IDs both fall through to target 0.
      assign addr = head[gi][addr_lsb_p +: addr_width_p];
      always_comb begin
        dec    = '0;
        dec[0] = 1'b1;
        if (addr < dram_base_p) begin
          for (int t = 1; t < num_tgt_p; t++) begin
            if (addr[dev_lsb_p +: 4] == tgt_dev_map_p[4*(t-1) +: 4]) begin
              dec    = '0;
              dec[t] = 1'b1;
            end
          end
        end
      end
      assign head_tgt[gi] = dec;

      assign cred_full[gi]  = (cnt_reg == cred_w'(max_outstanding_p));
      assign cred_empty[gi] = (cnt_reg == '0);
      assign underflow[gi]  = resp_acc[gi] & ~deq[gi] & cred_empty[gi];
      assign bus.credits_full_o[gi]  = cred_full[gi];
      assign bus.credits_empty_o[gi] = cred_empty[gi];

      always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i)
          cnt_reg <= '0;
        else if (deq[gi] && !resp_acc[gi])
          cnt_reg <= cnt_reg + cred_w'(1);
        else if (resp_acc[gi] && !deq[gi] && !cred_empty[gi])
          cnt_reg <= cnt_reg - cred_w'(1);
      end

      always_comb begin
        for (int t = 0; t < num_tgt_p; t++)
          rreq[t] = resp_v[t] & (resp_id[t] == id_width_p'(gi));
      end

      bp_mem_cmd_xbar_rr_arb #(.n_p(num_tgt_p), .rr_p(rr_mode_p)) u_resp_arb (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .req       (rreq),
        .advance   (resp_acc[gi]),
        .grant     (resp_grant[gi]),
        .idx       (resp_idx[gi]),
        .v         (bus.req_resp_v_o[gi])
      );

      assign resp_acc[gi] = bus.req_resp_v_o[gi] & bus.req_resp_yumi_i[gi];
      assign bus.req_resp_o[gi*msg_width_p +: msg_width_p] =
        bus.tgt_resp_i[resp_idx[gi]*msg_width_p +: msg_width_p];
    end

    for (gi = 0; gi < num_tgt_p; gi++) begin : g_tgt
      logic [num_req_p-1:0] elig;
      logic                 yumi;

      assign resp_id[gi]  = bus.tgt_resp_i[gi*msg_width_p + id_lsb_p +: id_width_p];
      assign resp_v[gi]   = reset_n_i & bus.tgt_resp_v_i[gi];
      assign resp_bad[gi] = resp_v[gi] & (int'(resp_id[gi]) >= num_req_p);

      always_comb begin
        for (int r = 0; r < num_req_p; r++)
          elig[r] = head_v[r] & head_tgt[r][gi] & ~cred_full[r];
      end

      bp_mem_cmd_xbar_rr_arb #(.n_p(num_req_p), .rr_p(rr_mode_p)) u_cmd_arb (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .req       (elig),
        .advance   (cmd_hs[gi]),
        .grant     (cmd_grant[gi]),
        .idx       (cmd_idx[gi]),
        .v         (bus.tgt_cmd_v_o[gi])
      );

      assign cmd_hs[gi] = bus.tgt_cmd_v_o[gi] & bus.tgt_cmd_ready_i[gi];
      assign bus.tgt_cmd_o[gi*msg_width_p +: msg_width_p] = head[cmd_idx[gi]];

      // Messages with an out-of-range lce_id are consumed here so they cannot block the target.
      always_comb begin
        yumi = resp_bad[gi];
        for (int r = 0; r < num_req_p; r++)
          yumi = yumi | (resp_grant[r][gi] & resp_acc[r]);
      end
      assign bus.tgt_resp_yumi_o[gi] = yumi;
    end
  endgenerate

  always_comb begin
    deq = '0;
    for (int t = 0; t < num_tgt_p; t++)
      for (int r = 0; r < num_req_p; r++)
        deq[r] = deq[r] | (cmd_hs[t] & cmd_grant[t][r]);
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i)
      err_reg <= 1'b0;
    else if ((|resp_bad) || (|underflow))
      err_reg <= 1'b1;
  end
  assign bus.err_o = err_reg;

endmodule

// File: tb/tb_bp_mem_cmd_xbar.sv
// Directed bench for bp_mem_cmd_xbar: one round-robin instance plus a fixed-priority one.
module tb_bp_mem_cmd_xbar;

  logic clk = 1'b0;
  logic reset_n;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  bp_mem_cmd_xbar_if #(.num_req_p(2), .num_tgt_p(3), .msg_width_p(512)) bi ();
  bp_mem_cmd_xbar_if #(.num_req_p(2), .num_tgt_p(3), .msg_width_p(512)) fi ();

  bp_mem_cmd_xbar dut (.clk_i(clk), .reset_n_i(reset_n), .bus(bi));
  bp_mem_cmd_xbar #(.rr_mode_p(1'b0)) dut_fx (.clk_i(clk), .reset_n_i(reset_n), .bus(fi));

  function automatic logic [511:0] mk(input logic [39:0] a, input logic [3:0] id,
                                      input logic [15:0] tag);
    logic [511:0] m;
    m = '0;
    m[39:0]  = a;
    m[43:40] = id;
    m[63:48] = tag;
    return m;
  endfunction

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [511:0] m0, m1, m2;
  int           sr [2];
  int           sf [2];
  int           gr, gf;
  logic [7:0]   ord_r, ord_f;

  initial begin
    reset_n = 1'b0;
    bi.req_cmd_i = '0; bi.req_cmd_v_i = '0; bi.req_resp_yumi_i = '0;
    bi.tgt_cmd_ready_i = '0; bi.tgt_resp_i = '0; bi.tgt_resp_v_i = '0;
    fi.req_cmd_i = '0; fi.req_cmd_v_i = '0; fi.req_resp_yumi_i = '0;
    fi.tgt_cmd_ready_i = '0; fi.tgt_resp_i = '0; fi.tgt_resp_v_i = '0;

    // Reset held: a pending response must not leak through.
    bi.tgt_resp_i[511:0] = mk(40'h0, 4'd0, 16'h0001);
    bi.tgt_resp_v_i = 3'b001;
    bi.req_resp_yumi_i = 2'b01;
    #2;
    chk("rst_ready", bi.req_cmd_ready_o, 2'b00);
    chk("rst_empty", bi.credits_empty_o, 2'b11);
    chk("rst_full", bi.credits_full_o, 2'b00);
    chk("rst_tgt_v", bi.tgt_cmd_v_o, 3'b000);
    chk("rst_resp_v", bi.req_resp_v_o, 2'b00);
    chk("rst_yumi", bi.tgt_resp_yumi_o, 3'b000);
    chk("rst_err", bi.err_o, 1'b0);
    bi.tgt_resp_v_i = '0;
    bi.req_resp_yumi_i = '0;
    tick();
    #2 reset_n = 1'b1;
    tick();

    // Single mem command: visible only after the enqueue edge.
    m0 = mk(40'h00_8000_1000, 4'd0, 16'h0010);
    bi.req_cmd_i[511:0] = m0;
    bi.req_cmd_v_i = 2'b01;
    #1;
    chk("t1_ready", bi.req_cmd_ready_o, 2'b11);
    chk("t1_v_same_cycle", bi.tgt_cmd_v_o, 3'b000);
    tick();
    bi.req_cmd_v_i = 2'b00;
    #1;
    chk("t1_tgt_v", bi.tgt_cmd_v_o, 3'b001);
    chk("t1_tgt_cmd", bi.tgt_cmd_o[511:0], m0);
    bi.tgt_cmd_ready_i = 3'b111;
    tick();
    chk("t1_tgt_v_after", bi.tgt_cmd_v_o, 3'b000);
    chk("t1_empty", bi.credits_empty_o, 2'b10);

    // Two device targets granted in the same cycle.
    m0 = mk(40'h00_0020_0000, 4'd0, 16'h0020);
    m1 = mk(40'h00_0010_0000, 4'd1, 16'h0021);
    bi.req_cmd_i = {m1, m0};
    bi.req_cmd_v_i = 2'b11;
    tick();
    bi.req_cmd_v_i = 2'b00;
    #1;
    chk("t2_tgt_v", bi.tgt_cmd_v_o, 3'b110);
    chk("t2_cmd1", bi.tgt_cmd_o[1*512 +: 512], m1);
    chk("t2_cmd2", bi.tgt_cmd_o[2*512 +: 512], m0);
    tick();
    chk("t2_tgt_v_after", bi.tgt_cmd_v_o, 3'b000);
    chk("t2_empty", bi.credits_empty_o, 2'b00);

    // Drain credits (req0 owes 2, req1 owes 1); the id1 reply comes from target 2.
    m0 = mk(40'h0, 4'd0, 16'h0030);
    m2 = mk(40'h0, 4'd1, 16'h0032);
    bi.tgt_resp_i[0 +: 512] = m0;
    bi.tgt_resp_i[1024 +: 512] = m2;
    bi.tgt_resp_v_i = 3'b101;
    bi.req_resp_yumi_i = 2'b11;
    #1;
    chk("dr_resp_v", bi.req_resp_v_o, 2'b11);
    chk("dr_yumi", bi.tgt_resp_yumi_o, 3'b101);
    chk("dr_resp1", bi.req_resp_o[512 +: 512], m2);
    tick();
    bi.tgt_resp_v_i = 3'b001;
    bi.req_resp_yumi_i = 2'b01;
    #1;
    chk("dr_resp0", bi.req_resp_o[0 +: 512], m0);
    tick();
    bi.tgt_resp_v_i = 3'b000;
    bi.req_resp_yumi_i = 2'b00;
    #1;
    chk("dr_empty", bi.credits_empty_o, 2'b11);

    // Contention on mem, 4 commands each. The mem pointer sits at 1 after the first
    // handshake from req0, so round-robin starts with req1.
    fi.tgt_cmd_ready_i = 3'b001;
    sr[0] = 0; sr[1] = 0; sf[0] = 0; sf[1] = 0;
    gr = 0; gf = 0; ord_r = '0; ord_f = '0;
    for (int cyc = 0; cyc < 30 && (gr < 8 || gf < 8); cyc++) begin
      for (int r = 0; r < 2; r++) begin
        bi.req_cmd_v_i[r] = (sr[r] < 4);
        bi.req_cmd_i[r*512 +: 512] = mk(40'h00_8000_0000 + 40'(sr[r] * 64), 4'(r), 16'(r * 16 + sr[r]));
        fi.req_cmd_v_i[r] = (sf[r] < 4);
        fi.req_cmd_i[r*512 +: 512] = mk(40'h00_8000_0000 + 40'(sf[r] * 64), 4'(r), 16'(r * 16 + sf[r]));
      end
      #1;
      for (int r = 0; r < 2; r++) begin
        if (bi.req_cmd_v_i[r] && bi.req_cmd_ready_o[r]) sr[r]++;
        if (fi.req_cmd_v_i[r] && fi.req_cmd_ready_o[r]) sf[r]++;
      end
      if (bi.tgt_cmd_v_o[0] && gr < 8) begin
        ord_r[gr] = bi.tgt_cmd_o[40];
        gr++;
      end
      if (fi.tgt_cmd_v_o[0] && gf < 8) begin
        ord_f[gf] = fi.tgt_cmd_o[40];
        gf++;
      end
      tick();
    end
    bi.req_cmd_v_i = 2'b00;
    fi.req_cmd_v_i = 2'b00;
    #1;
    chk("t3_rr_count", gr, 8);
    chk("t3_rr_order", ord_r, 8'b0101_0101);
    chk("t3_fx_count", gf, 8);
    chk("t3_fx_order", ord_f, 8'b1111_0000);
    chk("t3_rr_full", bi.credits_full_o, 2'b11);
    chk("t3_fx_full", fi.credits_full_o, 2'b11);
    chk("t3_tgt_v", bi.tgt_cmd_v_o, 3'b000);
    tick();

    // Fifth command waits for a credit to return.
    m0 = mk(40'h00_8000_2000, 4'd0, 16'h0055);
    bi.req_cmd_i[511:0] = m0;
    bi.req_cmd_v_i = 2'b01;
    tick();
    bi.req_cmd_v_i = 2'b00;
    #1;
    chk("t4_blocked_a", bi.tgt_cmd_v_o, 3'b000);
    tick();
    chk("t4_blocked_b", bi.tgt_cmd_v_o, 3'b000);
    m1 = mk(40'h0, 4'd0, 16'h00b0);
    bi.tgt_resp_i[0 +: 512] = m1;
    bi.tgt_resp_v_i = 3'b001;
    bi.req_resp_yumi_i = 2'b01;
    #1;
    chk("t4_resp_v", bi.req_resp_v_o, 2'b01);
    chk("t4_yumi", bi.tgt_resp_yumi_o, 3'b001);
    chk("t4_resp0", bi.req_resp_o[0 +: 512], m1);
    chk("t4_blocked_c", bi.tgt_cmd_v_o, 3'b000);
    tick();
    bi.tgt_resp_v_i = 3'b000;
    bi.req_resp_yumi_i = 2'b00;
    #1;
    chk("t4_issue_v", bi.tgt_cmd_v_o, 3'b001);
    chk("t4_issue_cmd", bi.tgt_cmd_o[511:0], m0);
    chk("t4_full_mid", bi.credits_full_o, 2'b10);
    tick();
    chk("t4_full_end", bi.credits_full_o, 2'b11);

    // Targets 0 and 2 both answer req1; delivery alternates 0,2,0,2.
    m0 = mk(40'h0, 4'd1, 16'h00a0);
    m2 = mk(40'h0, 4'd1, 16'h00a2);
    bi.tgt_resp_i[0 +: 512] = m0;
    bi.tgt_resp_i[1024 +: 512] = m2;
    bi.tgt_resp_v_i = 3'b101;
    #1;
    chk("t5_resp_v", bi.req_resp_v_o, 2'b10);
    chk("t5_yumi_hold", bi.tgt_resp_yumi_o, 3'b000);
    tick();
    bi.req_resp_yumi_i = 2'b10;
    #1;
    chk("t5_yumi_a", bi.tgt_resp_yumi_o, 3'b001);
    chk("t5_data_a", bi.req_resp_o[512 +: 512], m0);
    tick();
    chk("t5_yumi_b", bi.tgt_resp_yumi_o, 3'b100);
    chk("t5_data_b", bi.req_resp_o[512 +: 512], m2);
    tick();
    chk("t5_yumi_c", bi.tgt_resp_yumi_o, 3'b001);
    tick();
    chk("t5_yumi_d", bi.tgt_resp_yumi_o, 3'b100);
    tick();
    bi.tgt_resp_v_i = 3'b000;
    bi.req_resp_yumi_i = 2'b00;
    #1;
    chk("t5_empty", bi.credits_empty_o, 2'b10);
    chk("t5_err", bi.err_o, 1'b0);

    // Out-of-range lce_id is dropped and flags a sticky error.
    bi.tgt_resp_i[512 +: 512] = mk(40'h0, 4'd7, 16'h00ee);
    bi.tgt_resp_v_i = 3'b010;
    #1;
    chk("t6_drop_yumi", bi.tgt_resp_yumi_o, 3'b010);
    chk("t6_drop_resp_v", bi.req_resp_v_o, 2'b00);
    tick();
    bi.tgt_resp_v_i = 3'b000;
    #1;
    chk("t6_err_set", bi.err_o, 1'b1);
    bi.tgt_cmd_ready_i = 3'b000;
    bi.req_cmd_i[512 +: 512] = mk(40'h00_8000_3000, 4'd1, 16'h0077);
    bi.req_cmd_v_i = 2'b10;
    tick();
    bi.req_cmd_v_i = 2'b00;
    #1;
    chk("t6_err_sticky", bi.err_o, 1'b1);
    chk("t6_pending_v", bi.tgt_cmd_v_o, 3'b001);
    #1 reset_n = 1'b0;
    #1;
    chk("t6_async_err", bi.err_o, 1'b0);
    chk("t6_async_empty", bi.credits_empty_o, 2'b11);
    chk("t6_async_tgt_v", bi.tgt_cmd_v_o, 3'b000);
    chk("t6_async_ready", bi.req_cmd_ready_o, 2'b00);
    #1 reset_n = 1'b1;
    tick();
    chk("t6_post_ready", bi.req_cmd_ready_o, 2'b11);
    chk("t6_post_tgt_v", bi.tgt_cmd_v_o, 3'b000);

    // Response with no outstanding credit underflows and sets the error.
    m0 = mk(40'h0, 4'd0, 16'h00cc);
    bi.tgt_resp_i[0 +: 512] = m0;
    bi.tgt_resp_v_i = 3'b001;
    bi.req_resp_yumi_i = 2'b01;
    #1;
    chk("t7_resp_v", bi.req_resp_v_o, 2'b01);
    tick();
    bi.tgt_resp_v_i = 3'b000;
    bi.req_resp_yumi_i = 2'b00;
    #1;
    chk("t7_underflow_err", bi.err_o, 1'b1);
    chk("t7_empty_hold", bi.credits_empty_o, 2'b11);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
